// File: rtl/alu_pkg.sv
// Shared encodings and widths for the ALU operand stage.
// Optional feature: ALU_OPERAND_STAGE_FORWARD_EN (writeback-to-read forwarding in the top).
package alu_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        FUNC_AND = 2'b00,
        FUNC_OR  = 2'b01,
        FUNC_ADD = 2'b10,
        FUNC_SUB = 2'b11
    } func_t;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10
    } op_t;

    typedef struct packed {
        op_t  op;
        logic binvert;
    } ctrl_t;

    // SUB reuses the adder with the B operand inverted and a carry-in of one.
    function automatic ctrl_t func_to_ctrl(input func_t f);
        ctrl_t c;
        c = '{op: OP_AND, binvert: 1'b0};
        case (f)
            FUNC_AND: c = '{op: OP_AND, binvert: 1'b0};
            FUNC_OR:  c = '{op: OP_OR,  binvert: 1'b0};
            FUNC_ADD: c = '{op: OP_ADD, binvert: 1'b0};
            FUNC_SUB: c = '{op: OP_ADD, binvert: 1'b1};
            default:  c = '{op: OP_AND, binvert: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8 x 32 register file: two combinational read ports, one synchronous write port.
// r0 is hardwired to zero; all entries clear on reset.
module alu_regfile
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_a,
    output logic [DATA_W-1:0]     rdata_b,
    input  logic                  wen,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: reads the register file, decodes ALU controls and holds them behind a
// valid/ready handshake. Define ALU_OPERAND_STAGE_FORWARD_EN to forward same-cycle writebacks.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_func,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     a,
    output logic [DATA_W-1:0]     b,
    output logic [1:0]            Operation,
    output logic                  Binvert,
    output logic                  Carryin,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [15:0]           issue_count
);

    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              accept;
    ctrl_t             ctrl;

    alu_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (in_rs),
        .raddr_b (in_rt),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .wen     (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

`ifdef ALU_OPERAND_STAGE_FORWARD_EN
    assign opnd_a = (wb_en && (wb_addr == in_rs) && (in_rs != '0)) ? wb_data : rdata_a;
    assign opnd_b = (wb_en && (wb_addr == in_rt) && (in_rt != '0)) ? wb_data : rdata_b;
`else
    assign opnd_a = rdata_a;
    assign opnd_b = rdata_b;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign ctrl     = func_to_ctrl(func_t'(in_func));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            a           <= '0;
            b           <= '0;
            Operation   <= OP_AND;
            Binvert     <= 1'b0;
            Carryin     <= 1'b0;
            out_rd      <= '0;
            issue_count <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            a           <= opnd_a;
            b           <= opnd_b;
            Operation   <= ctrl.op;
            Binvert     <= ctrl.binvert;
            Carryin     <= ctrl.binvert;
            out_rd      <= in_rd;
            issue_count <= issue_count + 16'd1;
        end else if (out_valid && out_ready) begin
            // Operand fields keep their last values; only the valid flag drops.
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: an instruction is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: the stage accepts an instruction this cycle.
REQ-005 SHALL have port in_func, input, 2 bits: operation code, where 00=AND, 01=OR, 10=ADD and 11=SUB.
REQ-006 SHALL have ports in_rs, in_rt and in_rd, inputs, 3 bits each: source and destination register indices.
REQ-007 SHALL have port wb_en, input, 1 bit: writeback enable.
REQ-008 SHALL have port wb_addr, input, 3 bits, and port wb_data, input, 32 bits: the writeback target and its value.
REQ-009 SHALL have port out_valid, output, 1 bit: operands for the ALU are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream ALU stage consumes the operands.
REQ-011 SHALL have ports a and b, outputs, 32 bits each: the ALU operands.
REQ-012 SHALL have port Operation, output, 2 bits, and ports Binvert and Carryin, outputs, 1 bit each: the ALU controls.
REQ-013 SHALL have port out_rd, output, 3 bits: destination index passed through for writeback.
REQ-014 SHALL have port issue_count, output, 16 bits: running count of accepted instructions.

Function
REQ-015 SHALL hold an 8 x 32 register file; r0 reads 0; writes to r0 are ignored.
REQ-016 SHALL write wb_data to wb_addr on each rising edge where wb_en=1.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL treat an instruction as accepted when in_valid && in_ready; on the next edge it SHALL register a=R[in_rs], b=R[in_rt], out_rd=in_rd and the controls, and set out_valid=1, giving one-cycle latency.
REQ-019 SHALL map the controls as: AND gives Operation=00, Binvert=0; OR gives Operation=01, Binvert=0; ADD gives Operation=10, Binvert=0; SUB gives Operation=10, Binvert=1.
REQ-020 SHALL drive Carryin equal to Binvert.
REQ-021 SHALL clear out_valid on the edge where out_valid && out_ready && !in_valid.
REQ-022 SHALL, on a back-to-back accept (out_ready=1 and in_valid=1), replace the outputs with no bubble.
REQ-023 SHALL hold a, b, the controls and out_rd stable while out_valid && !out_ready; a writeback during a stall SHALL NOT alter the held operands.
REQ-024 SHALL increment issue_count by 1 per accept and wrap from 0xFFFF to 0x0000.

Reset
REQ-025 SHALL, while reset=1, force out_valid=0, a=0, b=0, Operation=00, Binvert=0, Carryin=0, out_rd=0, issue_count=0 and every register to 0, independent of clk.
REQ-026 SHALL discard an in-flight or stalled instruction on reset mid-operation, and SHALL NOT perform a writeback in that cycle.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with macro ALU_OPERAND_STAGE_FORWARD_EN defined, return wb_data for any read where wb_en=1 and wb_addr equals in_rs or in_rt (nonzero) in the same cycle as the accept.
REQ-029 SHALL, without ALU_OPERAND_STAGE_FORWARD_EN, return the pre-write register value in that case.

Structure
REQ-030 SHALL place the func encodings (FUNC_AND/OR/ADD/SUB), the ALU Operation encodings (OP_AND=00, OP_OR=01, OP_ADD=10), REG_ADDR_W=3 and DATA_W=32 in a shared package alu_pkg.
REQ-031 SHALL implement the register file as sub-module alu_regfile, with two combinational read ports and one synchronous write port, reset to 0.

Verification
REQ-032 SHALL cover: write r1=0xa5a5a5a5 and r2=0x5a5a5a5a, issue AND r1,r2 -> one cycle later out_valid=1, a=0xa5a5a5a5, b=0x5a5a5a5a, Operation=00, Binvert=0.
REQ-033 SHALL cover: issue SUB r1,r2 with rd=3 -> Operation=10, Binvert=1, Carryin=1, out_rd=3.
REQ-034 SHALL cover: hold out_ready=0 for 3 cycles while writing r1=0 -> in_ready=0, and a stays 0xa5a5a5a5.
REQ-035 SHALL cover: accept a read of r1 while wb writes r1=0x12345678 -> a=0x12345678 with FORWARD_EN, and a=0xa5a5a5a5 without it.
REQ-036 SHALL cover: read r0 after writing r0=0xFFFFFFFF -> a=0; and 65536 accepts -> issue_count=0.
REQ-037 SHALL cover: assert reset mid-stall -> out_valid=0, all registers read 0 and issue_count=0 immediately, without waiting for a clock edge.
